// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned approximate multiplier: high partial-product rows exact, low rows OR-compressed
// below column W-1. Optional out_err port (exact - approximate) enabled by macro APPROX_ERR_OUT_EN.
module approx_mult_pipe #(
  parameter int W = 8,
  parameter int L = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_x,
  input  logic [W-1:0]    in_y,
  input  logic            in_exact,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_z
`ifdef APPROX_ERR_OUT_EN
  ,
  output logic [2*W-1:0]  out_err
`endif
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(L + 1) + 1;

  logic          adv;
  logic          in_fire;
  logic          s1_valid;
  logic [W-1:0]  s1_x;
  logic [W-1:0]  s1_y;
  logic          s1_exact;
  logic [PW-1:0] s1_hi;
  logic [PW-1:0] s1_lo;

  logic [PW-1:0] hi_c;
  logic [PW-1:0] lo_c;
  logic [CW-1:0] col_cnt [PW];
  logic [PW-1:0] prod_c;
  logic [PW-1:0] approx_c;
  logic [PW-1:0] z_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv || !s1_valid;
  assign in_fire  = in_valid && in_ready;

  assign hi_c = (PW'(in_y) * (PW'(in_x) >> L)) << L;

  // Low rows: column population counts; columns below W-1 collapse to a single OR bit.
  always_comb begin
    for (int c = 0; c < PW; c++) begin
      col_cnt[c] = '0;
    end
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < W; j++) begin
        col_cnt[i+j] = col_cnt[i+j] + CW'(in_x[i] & in_y[j]);
      end
    end
    lo_c = '0;
    for (int c = 0; c < PW; c++) begin
      if (c < W - 1) begin
        lo_c[c] = |col_cnt[c];
      end else begin
        lo_c = lo_c + (PW'(col_cnt[c]) << c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_exact <= 1'b0;
      s1_hi    <= '0;
      s1_lo    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_x     <= in_x;
        s1_y     <= in_y;
        s1_exact <= in_exact;
        s1_hi    <= hi_c;
        s1_lo    <= lo_c;
      end
    end
  end

  assign prod_c   = PW'(s1_x) * PW'(s1_y);
  assign approx_c = s1_hi + s1_lo;
  assign z_c      = s1_exact ? prod_c : approx_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_z <= z_c;
      end
    end
  end

`ifdef APPROX_ERR_OUT_EN
  logic [PW-1:0] err_c;

  assign err_c = s1_exact ? '0 : (prod_c - approx_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err <= '0;
    end else if (adv && s1_valid) begin
      out_err <= err_c;
    end
  end
`endif

endmodule
